// File: rtl/dbus_pkg.sv
// Shared types and default address map for the data-bus arbiter and decoder.
package dbus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_e;

  typedef enum logic [1:0] {
    T_DMEM = 2'd0,
    T_IO   = 2'd1,
    T_NONE = 2'd2
  } target_e;

  localparam logic [15:0]   DMEM_BASE_DEF = 16'h0000;
  localparam logic [15:0]   DMEM_LIMIT_DEF = 16'h07FF;
  localparam logic [15:0]   IO_BASE_DEF   = 16'h1000;
  localparam logic [15:0]   IO_LIMIT_DEF  = 16'h10FF;
  localparam int unsigned   MAX_BURST_DEF = 4;

endpackage

// File: rtl/dbus_decode.sv
// Combinational address-to-target decode; both range limits are inclusive.
module dbus_decode
  import dbus_pkg::*;
#(
  parameter logic [15:0] DMEM_BASE  = DMEM_BASE_DEF,
  parameter logic [15:0] DMEM_LIMIT = DMEM_LIMIT_DEF,
  parameter logic [15:0] IO_BASE    = IO_BASE_DEF,
  parameter logic [15:0] IO_LIMIT   = IO_LIMIT_DEF
) (
  input  logic [15:0] i_addr,
  output target_e     o_target
);

  localparam logic [15:0] LP_DMEM_SPAN = DMEM_LIMIT - DMEM_BASE;
  localparam logic [15:0] LP_IO_SPAN   = IO_LIMIT - IO_BASE;

  // Offset-from-base compare: one unsigned test covers both range ends
  // without a constant-true compare when a base is zero.
  logic [15:0] w_dmem_off;
  logic [15:0] w_io_off;

  assign w_dmem_off = i_addr - DMEM_BASE;
  assign w_io_off   = i_addr - IO_BASE;

  // Pick the target region for the current address.
  always_comb begin
    o_target = T_NONE;
    if (w_dmem_off <= LP_DMEM_SPAN) begin
      o_target = T_DMEM;
    end else if (w_io_off <= LP_IO_SPAN) begin
      o_target = T_IO;
    end
  end

endmodule

// File: rtl/dbus_arbiter.sv
// Two-master round-robin data-bus arbiter with burst cap, address decode
// and registered read-return routing.
module dbus_arbiter
  import dbus_pkg::*;
#(
  parameter logic [15:0] DMEM_BASE  = DMEM_BASE_DEF,
  parameter logic [15:0] DMEM_LIMIT = DMEM_LIMIT_DEF,
  parameter logic [15:0] IO_BASE    = IO_BASE_DEF,
  parameter logic [15:0] IO_LIMIT   = IO_LIMIT_DEF,
  parameter int unsigned MAX_BURST  = MAX_BURST_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic [15:0] m0_addr,
  input  logic        m0_we,
  input  logic [7:0]  m0_wdata,
  output logic        m0_gnt,
  output logic [7:0]  m0_rdata,
  output logic        m0_rvalid,
  input  logic        m1_req,
  input  logic [15:0] m1_addr,
  input  logic        m1_we,
  input  logic [7:0]  m1_wdata,
  output logic        m1_gnt,
  output logic [7:0]  m1_rdata,
  output logic        m1_rvalid,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        dmem_w_en,
  output logic        dmem_r_en,
  output logic        io_w_en,
  output logic        io_r_en,
  input  logic [7:0]  dmem_rdata,
  input  logic [7:0]  io_rdata,
  output logic        bus_err
);

  localparam logic [3:0] LP_MAX = MAX_BURST[3:0];

  owner_e      r_state;
  logic        r_last_m1;
  logic [3:0]  r_count;
  logic        r_rd_pend;
  logic        r_rd_m1;
  target_e     r_rd_tgt;
  logic        r_err;

  logic        w_own1;
  logic        w_gnt;
  logic        w_we;
  target_e     w_target;
  logic [3:0]  w_cnt_inc;
  logic [3:0]  w_cnt_next;
  logic [7:0]  w_rdata;

  // Owner mux: in IDLE m0 is presented but nothing is granted.
  assign w_own1    = (r_state == OWN1);
  assign m0_gnt    = (r_state == OWN0) & m0_req;
  assign m1_gnt    = w_own1 & m1_req;
  assign w_gnt     = m0_gnt | m1_gnt;
  assign w_we      = w_own1 ? m1_we : m0_we;
  assign bus_addr  = w_own1 ? m1_addr : m0_addr;
  assign bus_wdata = w_own1 ? m1_wdata : m0_wdata;

  dbus_decode #(
    .DMEM_BASE  (DMEM_BASE),
    .DMEM_LIMIT (DMEM_LIMIT),
    .IO_BASE    (IO_BASE),
    .IO_LIMIT   (IO_LIMIT)
  ) u_decode (
    .i_addr   (bus_addr),
    .o_target (w_target)
  );

  assign dmem_w_en = w_gnt & (w_target == T_DMEM) &  w_we;
  assign dmem_r_en = w_gnt & (w_target == T_DMEM) & ~w_we;
  assign io_w_en   = w_gnt & (w_target == T_IO)   &  w_we;
  assign io_r_en   = w_gnt & (w_target == T_IO)   & ~w_we;

  // Burst count including this cycle's access, saturating at the cap.
  assign w_cnt_inc  = (r_count == LP_MAX) ? r_count : r_count + 4'd1;
  assign w_cnt_next = w_gnt ? w_cnt_inc : r_count;

  // Ownership FSM with round-robin tie break and burst-cap handover.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_last_m1 <= 1'b1;
      r_count   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_count <= '0;
          if (m0_req && m1_req) begin
            r_state <= r_last_m1 ? OWN0 : OWN1;
          end else if (m0_req) begin
            r_state <= OWN0;
          end else if (m1_req) begin
            r_state <= OWN1;
          end
        end
        OWN0: begin
          if (!m0_req) begin
            r_last_m1 <= 1'b0;
            r_count   <= '0;
            r_state   <= m1_req ? OWN1 : IDLE;
          end else if (m1_req && (w_cnt_next == LP_MAX)) begin
            r_last_m1 <= 1'b0;
            r_count   <= '0;
            r_state   <= OWN1;
          end else begin
            r_count <= w_cnt_next;
          end
        end
        OWN1: begin
          if (!m1_req) begin
            r_last_m1 <= 1'b1;
            r_count   <= '0;
            r_state   <= m0_req ? OWN0 : IDLE;
          end else if (m0_req && (w_cnt_next == LP_MAX)) begin
            r_last_m1 <= 1'b1;
            r_count   <= '0;
            r_state   <= OWN0;
          end else begin
            r_count <= w_cnt_next;
          end
        end
        default: begin
          r_state <= IDLE;
          r_count <= '0;
        end
      endcase
    end
  end

  // Register read origin/target and unmapped-access error for next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_pend <= 1'b0;
      r_rd_m1   <= 1'b0;
      r_rd_tgt  <= T_NONE;
      r_err     <= 1'b0;
    end else begin
      r_rd_pend <= w_gnt & ~w_we;
      r_rd_m1   <= w_own1;
      r_rd_tgt  <= w_target;
      r_err     <= w_gnt & (w_target == T_NONE);
    end
  end

  // Return-data select from the target captured with the read.
  always_comb begin
    w_rdata = '0;
    case (r_rd_tgt)
      T_DMEM:  w_rdata = dmem_rdata;
      T_IO:    w_rdata = io_rdata;
      default: w_rdata = '0;
    endcase
  end

  assign m0_rvalid = r_rd_pend & ~r_rd_m1;
  assign m1_rvalid = r_rd_pend &  r_rd_m1;
  assign m0_rdata  = m0_rvalid ? w_rdata : '0;
  assign m1_rdata  = m1_rvalid ? w_rdata : '0;
  assign bus_err   = r_err;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed self-checking bench for dbus_arbiter with simple d_ram/io models.
module tb_dbus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 1'b0, m1_req = 1'b0;
  logic [15:0] m0_addr = '0, m1_addr = '0;
  logic        m0_we = 1'b0, m1_we = 1'b0;
  logic [7:0]  m0_wdata = '0, m1_wdata = '0;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [7:0]  m0_rdata, m1_rdata;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        dmem_w_en, dmem_r_en, io_w_en, io_r_en, bus_err;
  logic [7:0]  dmem_rdata = '0;
  logic [7:0]  io_rdata = '0;

  logic [7:0]  dmem [0:2047];
  logic [7:0]  iomem [0:255];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dbus_arbiter #(
    .DMEM_BASE  (16'h0000),
    .DMEM_LIMIT (16'h07FF),
    .IO_BASE    (16'h1000),
    .IO_LIMIT   (16'h10FF),
    .MAX_BURST  (4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .dmem_w_en(dmem_w_en), .dmem_r_en(dmem_r_en),
    .io_w_en(io_w_en), .io_r_en(io_r_en),
    .dmem_rdata(dmem_rdata), .io_rdata(io_rdata), .bus_err(bus_err)
  );

  // Synchronous-read target models.
  always @(posedge clk) begin
    if (dmem_w_en) dmem[bus_addr[10:0]] <= bus_wdata;
    if (dmem_r_en) dmem_rdata <= dmem[bus_addr[10:0]];
    if (io_w_en)   iomem[bus_addr[7:0]] <= bus_wdata;
    if (io_r_en)   io_rdata <= iomem[bus_addr[7:0]];
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    m0_req = 1'b1; m1_req = 1'b1; m0_addr = 16'h0005; m1_addr = 16'h0005;
    #12;
    checks++;
    if ({m0_gnt, m1_gnt, dmem_w_en, dmem_r_en, io_w_en, io_r_en,
         m0_rvalid, m1_rvalid, bus_err} !== 9'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 000000000",
               {m0_gnt, m1_gnt, dmem_w_en, dmem_r_en, io_w_en, io_r_en,
                m0_rvalid, m1_rvalid, bus_err});
    end
    checks++;
    if ({m0_rdata, m1_rdata} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_rdata: got %h want 0000", {m0_rdata, m1_rdata});
    end
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_read_basic;
    m0_req = 1'b1; m0_addr = 16'h0005; m0_we = 1'b0;
    #1;
    checks++;
    if (m0_gnt !== 1'b0) begin
      errors++; $display("FAIL rd_idle_nogrant: got %b want 0", m0_gnt);
    end
    tick();
    checks++;
    if ({m0_gnt, dmem_r_en, io_r_en} !== 3'b110) begin
      errors++; $display("FAIL rd_grant: got %b want 110", {m0_gnt, dmem_r_en, io_r_en});
    end
    tick();
    m0_req = 1'b0;
    #1;
    checks++;
    if ({m0_rvalid, m1_rvalid, m0_rdata} !== {2'b10, 8'hA5}) begin
      errors++; $display("FAIL rd_return: got %b/%h want 10/a5", {m0_rvalid, m1_rvalid}, m0_rdata);
    end
    tick();
    checks++;
    if (m0_rvalid !== 1'b0) begin
      errors++; $display("FAIL rd_pulse_len: got %b want 0", m0_rvalid);
    end
  endtask

  task automatic test_round_robin;
    logic [1:0] exp;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    m0_req = 1'b1; m0_addr = 16'h0005; m0_we = 1'b0;
    m1_req = 1'b1; m1_addr = 16'h0006; m1_we = 1'b0;
    for (int i = 0; i < 13; i++) begin
      #1;
      exp = (i == 0) ? 2'b00 : ((((i - 1) / 4) % 2) == 0) ? 2'b01 : 2'b10;
      checks++;
      if ({m1_gnt, m0_gnt} !== exp) begin
        errors++; $display("FAIL rr_cycle%0d: got %b want %b", i, {m1_gnt, m0_gnt}, exp);
      end
      @(posedge clk);
      #1;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_io_write;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'h1000; m1_wdata = 8'h3C;
    tick();
    checks++;
    if ({m1_gnt, io_w_en, dmem_w_en, bus_wdata} !== {3'b110, 8'h3C}) begin
      errors++; $display("FAIL io_wr_lo: got %b/%h want 110/3c", {m1_gnt, io_w_en, dmem_w_en}, bus_wdata);
    end
    tick();
    m1_addr = 16'h10FF; m1_wdata = 8'h7E;
    #1;
    checks++;
    if ({m1_gnt, io_w_en, dmem_w_en, bus_addr} !== {3'b110, 16'h10FF}) begin
      errors++; $display("FAIL io_wr_hi: got %b/%h want 110/10ff", {m1_gnt, io_w_en, dmem_w_en}, bus_addr);
    end
    tick();
    m1_addr = 16'h0800; m1_wdata = 8'h11;
    #1;
    checks++;
    if ({m1_gnt, io_w_en, dmem_w_en, io_r_en, dmem_r_en, bus_err} !== 6'b100000) begin
      errors++; $display("FAIL unmapped_wr_strobe: got %b want 100000",
                         {m1_gnt, io_w_en, dmem_w_en, io_r_en, dmem_r_en, bus_err});
    end
    tick();
    m1_req = 1'b0; m1_we = 1'b0;
    #1;
    checks++;
    if (bus_err !== 1'b1 || m1_rvalid !== 1'b0) begin
      errors++; $display("FAIL unmapped_wr_err: got %b%b want 10", bus_err, m1_rvalid);
    end
    tick();
    checks++;
    if (bus_err !== 1'b0) begin
      errors++; $display("FAIL err_pulse_len: got %b want 0", bus_err);
    end
    checks++;
    if ({iomem[0], iomem[255]} !== 16'h3C7E) begin
      errors++; $display("FAIL io_contents: got %h want 3c7e", {iomem[0], iomem[255]});
    end
  endtask

  task automatic test_unmapped_read;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h2000;
    tick();
    checks++;
    if ({m0_gnt, dmem_r_en, io_r_en} !== 3'b100) begin
      errors++; $display("FAIL unmapped_rd_grant: got %b want 100", {m0_gnt, dmem_r_en, io_r_en});
    end
    tick();
    m0_req = 1'b0;
    #1;
    checks++;
    if ({m0_rvalid, bus_err, m0_rdata} !== {2'b11, 8'h00}) begin
      errors++; $display("FAIL unmapped_rd_ret: got %b/%h want 11/00", {m0_rvalid, bus_err}, m0_rdata);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h07FF;
    tick();
    checks++;
    if ({m0_gnt, dmem_r_en} !== 2'b11) begin
      errors++; $display("FAIL b2b_first: got %b want 11", {m0_gnt, dmem_r_en});
    end
    tick();
    m0_addr = 16'h1001;
    #1;
    checks++;
    if ({m0_gnt, io_r_en, m0_rvalid, m0_rdata} !== {3'b111, 8'h5A}) begin
      errors++; $display("FAIL b2b_ret1: got %b/%h want 111/5a", {m0_gnt, io_r_en, m0_rvalid}, m0_rdata);
    end
    tick();
    m0_req = 1'b0;
    #1;
    checks++;
    if ({m0_rvalid, m0_rdata} !== {1'b1, 8'hC3}) begin
      errors++; $display("FAIL b2b_ret2: got %b/%h want 1/c3", m0_rvalid, m0_rdata);
    end
    tick();
    checks++;
    if (m0_rvalid !== 1'b0) begin
      errors++; $display("FAIL b2b_end: got %b want 0", m0_rvalid);
    end
  endtask

  task automatic test_reset_mid_read;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0005;
    tick();
    tick();
    rst_n = 1'b0;
    m0_req = 1'b0;
    #1;
    checks++;
    if ({m0_gnt, m1_gnt, dmem_r_en, dmem_w_en, io_r_en, io_w_en,
         m0_rvalid, m1_rvalid, bus_err, m0_rdata} !== 17'b0) begin
      errors++; $display("FAIL mid_rst_out: got %b/%h want all zero",
                         {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, bus_err}, m0_rdata);
    end
    tick();
    checks++;
    if (m0_rvalid !== 1'b0) begin
      errors++; $display("FAIL mid_rst_norvalid: got %b want 0", m0_rvalid);
    end
    rst_n = 1'b1;
    m0_req = 1'b1; m1_req = 1'b1; m0_addr = 16'h0005; m1_addr = 16'h1001;
    #1;
    checks++;
    if ({m1_gnt, m0_gnt} !== 2'b00) begin
      errors++; $display("FAIL post_rst_idle: got %b want 00", {m1_gnt, m0_gnt});
    end
    tick();
    checks++;
    if ({m1_gnt, m0_gnt} !== 2'b01) begin
      errors++; $display("FAIL post_rst_tie: got %b want 01", {m1_gnt, m0_gnt});
    end
    m0_req = 1'b0; m1_req = 1'b0;
    tick();
  endtask

  initial begin
    dmem[11'h005] = 8'hA5;
    dmem[11'h006] = 8'h66;
    dmem[11'h7FF] = 8'h5A;
    iomem[8'h01]  = 8'hC3;
    test_reset();
    test_read_basic();
    test_round_robin();
    test_io_write();
    test_unmapped_read();
    test_back_to_back();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
- Shares the data-memory/IO bus between two masters: m0, the CPU data port, and m1, a future DMA or UART-to-memory engine.
- Decodes the granted address into d_ram and io enables, and returns registered read data to the master that issued the read.
- Replaces the combinational top-level address decode: sits between the masters and the d_ram/io targets.
- Round-robin with a burst cap, so neither master starves.

Parameters:
DMEM_BASE, 16'h0000, first d_ram address
DMEM_LIMIT, 16'h07FF, last d_ram address (inclusive)
IO_BASE, 16'h1000, first io address
IO_LIMIT, 16'h10FF, last io address (inclusive)
MAX_BURST, 4, consecutive accesses allowed to the owner while the other master waits (range 1..15)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
m0_req / m1_req  in  1  access request; held with addr/we/wdata stable until gnt
m0_addr / m1_addr  in  16  byte address
m0_we / m1_we  in  1  1 = write, 0 = read
m0_wdata / m1_wdata  in  8  write data
m0_gnt / m1_gnt  out  1  access accepted this cycle
m0_rdata / m1_rdata  out  8  read data, valid with rvalid
m0_rvalid / m1_rvalid  out  1  one-cycle pulse, one cycle after a granted read
bus_addr  out  16  address to targets
bus_wdata  out  8  write data to targets
dmem_w_en, dmem_r_en  out  1  d_ram strobes
io_w_en, io_r_en  out  1  io strobes
dmem_rdata  in  8  d_ram dout; synchronous read, valid one cycle after r_en
io_rdata  in  8  io dout; same timing as dmem_rdata
bus_err  out  1  one-cycle pulse, one cycle after a granted access to an unmapped address

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE; last_owner=M1, so m0 wins the first tie.
  - Burst count = 0; all gnt, strobes, rvalid and bus_err = 0; rdata = 0.
- FSM states: IDLE, OWN0, OWN1.
- IDLE:
  - Exactly one req high → go to that master's OWN state.
  - Both high → go to the master that is not last_owner.
  - No grant is given in IDLE, so the first access costs 1 cycle of latency.
- OWNx:
  - mx_gnt = mx_req (combinational); the other gnt = 0.
  - Each cycle with gnt=1 issues exactly one access.
  - bus_addr and bus_wdata are muxed from the owner, so the access lands at the same clock edge it is granted.
  - Burst count increments on each granted access and saturates at MAX_BURST.
- Leaving OWNx (evaluated at each edge):
  - mx_req=0 and other req=1 → OWNother; count cleared.
  - mx_req=0 and other req=0 → IDLE.
  - mx_req=1, other req=1 and count==MAX_BURST (including the access in this cycle) → OWNother; count cleared.
  - Otherwise stay in OWNx.
  - last_owner is updated on every exit.
  - Switching between OWN0 and OWN1 inserts no idle cycle.
- Decode (combinational from bus_addr, qualified by gnt):
  - DMEM_BASE..DMEM_LIMIT → dmem_w_en = we, dmem_r_en = ~we.
  - IO_BASE..IO_LIMIT → io_w_en / io_r_en likewise.
  - Else unmapped: no strobe.
  - Limits are inclusive; both range ends must decode correctly.
- Read return:
  - A granted read registers {master, target}.
  - Next cycle: the matching rvalid pulses and rdata = dmem_rdata, io_rdata, or 8'h00 if unmapped.
  - The non-addressed master's rvalid stays 0.
  - Reads are pipelined: back-to-back granted reads produce back-to-back rvalid pulses.
- Unmapped access: a granted read or write sets bus_err=1 for one cycle, next cycle. An unmapped write is dropped.
- Requester drops req while it is the owner: no access is issued that cycle; an already registered read still returns rvalid next cycle.
- Reset mid-read: a pending rvalid is discarded.

Decomposition:
- Shared package dbus_pkg:
  - owner_e enum {IDLE, OWN0, OWN1}
  - target_e enum {T_DMEM, T_IO, T_NONE}
  - default address-map constants
- One sub-module, dbus_decode: pure combinational address-to-target_e decode. It is reused by the top-level SoC for the instruction/IO map.

Test Plan:
- Reset then m0 reads 16'h0005 (d_ram preloaded with 8'hA5) → m0_gnt at cycle 2, dmem_r_en=1 same cycle, m0_rvalid=1 and m0_rdata=8'hA5 at cycle 3.
- m0 and m1 both request from IDLE right after reset → OWN0 first. Under continuous requests, m0 gets exactly 4 grants, then m1 gets 4, alternating with no gap cycle.
- m1 writes 8'h3C to 16'h1000, then 8'h7E to 16'h10FF → io_w_en pulses twice, dmem_w_en=0. A write to 16'h0800 → no strobe, bus_err=1 next cycle.
- m0 reads 16'h2000 (unmapped) → m0_rvalid=1, m0_rdata=8'h00, bus_err=1 one cycle after grant.
- m0 does back-to-back reads of 16'h07FF and 16'h1001 → two consecutive rvalid pulses with the d_ram then io data.
- rst_n pulled low the cycle after a granted read → no rvalid, all outputs 0. After release, the FSM is in IDLE and m0 wins the next tie.
